// File: rtl/dmem_miss_responder.sv
// Data-memory responder for the core's d-side port: combinational load data,
// segfault detection, and a direct-mapped tag table with fixed-latency fills.
module dmem_miss_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16,
  parameter int MISS_LAT   = 8,
  parameter int MISS_EN    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wr_data,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [2:0]  d_trd,
  output logic [31:0] d_rd_data,
  output logic        d_miss,
  output logic        d_segfault,
  output logic [2:0]  fill_trd,
  output logic        busy,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WB  = $clog2(MEM_WORDS);
  localparam int LWB = $clog2(LINE_WORDS);
  localparam int IB  = $clog2(LINES);
  localparam int IW  = (IB > 0) ? IB : 1;
  localparam int TB  = WB - LWB - IB;
  localparam int TW  = (TB > 0) ? TB : 1;
  localparam int CW  = ($clog2(MISS_LAT + 1) > 0) ? $clog2(MISS_LAT + 1) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  typedef enum logic {IDLE, FILL} state_t;

  logic [31:0]      mem [MEM_WORDS];
  logic [TW-1:0]    tag_q [LINES];
  logic [LINES-1:0] valid;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    fill_idx;
  logic [TW-1:0]    fill_tag;

  logic          req, seg, legal, hit, tag_hit, do_hit, do_miss;
  logic [WB-1:0] word;
  logic [31:0]   line_full;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;

  assign req       = d_rd | d_wr;
  assign seg       = req & ((d_rd & d_wr) | (d_addr[1:0] != 2'b00) |
                            ({1'b0, d_addr} >= ADDR_LIMIT));
  assign legal     = req & ~seg;
  assign word      = d_addr[WB+1:2];
  assign line_full = 32'(word) >> LWB;
  assign idx       = IW'(line_full % LINES);
  assign tag       = TW'(line_full / LINES);

  // Lookups are blocked for the whole fill so only one line is ever in flight.
  assign tag_hit = (state == IDLE) && valid[idx] && (tag_q[idx] == tag);
  assign hit     = (MISS_EN == 0) || tag_hit;
  assign do_hit  = legal & hit;
  assign do_miss = legal & ~hit;

  assign d_rd_data  = (do_hit & d_rd) ? mem[word] : 32'd0;
  assign d_miss     = do_miss;
  assign d_segfault = seg;

  always_ff @(posedge clk) begin
    if (do_hit && d_wr)
      mem[word] <= d_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else begin
      if (do_hit && hit_cnt != 32'hFFFF_FFFF)
        hit_cnt <= hit_cnt + 32'd1;
      if (do_miss && miss_cnt != 32'hFFFF_FFFF)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      fill_trd <= 3'd0;
      cnt      <= '0;
      fill_idx <= '0;
      fill_tag <= '0;
      valid    <= '0;
      for (int i = 0; i < LINES; i++)
        tag_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_miss) begin
            state    <= FILL;
            fill_idx <= idx;
            fill_tag <= tag;
            fill_trd <= d_trd;
            cnt      <= CW'(MISS_LAT - 1);
            busy     <= 1'b1;
          end
        end
        FILL: begin
          if (cnt == '0) begin
            valid[fill_idx] <= 1'b1;
            tag_q[fill_idx] <= fill_tag;
            busy            <= 1'b0;
            state           <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_miss_responder.sv
// Scoreboard bench: directed requests push hand-computed expectations, a
// negedge monitor pops one entry per driven cycle and compares.
module tb_dmem_miss_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [2:0]  trd_s  [2];
  logic [31:0] rdd_s  [2];
  logic        miss_s [2];
  logic        seg_s  [2];
  logic [2:0]  ftrd_s [2];
  logic        busy_s [2];
  logic [31:0] hc_s   [2];
  logic [31:0] mc_s   [2];

  dmem_miss_responder #(.MISS_EN(1)) dut0 (
    .clk(clk), .rst(rst), .d_addr(addr_s[0]), .d_wr_data(wd_s[0]),
    .d_rd(rd_s[0]), .d_wr(wr_s[0]), .d_trd(trd_s[0]), .d_rd_data(rdd_s[0]),
    .d_miss(miss_s[0]), .d_segfault(seg_s[0]), .fill_trd(ftrd_s[0]),
    .busy(busy_s[0]), .hit_cnt(hc_s[0]), .miss_cnt(mc_s[0])
  );

  dmem_miss_responder #(.MISS_EN(0)) dut1 (
    .clk(clk), .rst(rst), .d_addr(addr_s[1]), .d_wr_data(wd_s[1]),
    .d_rd(rd_s[1]), .d_wr(wr_s[1]), .d_trd(trd_s[1]), .d_rd_data(rdd_s[1]),
    .d_miss(miss_s[1]), .d_segfault(seg_s[1]), .fill_trd(ftrd_s[1]),
    .busy(busy_s[1]), .hit_cnt(hc_s[1]), .miss_cnt(mc_s[1])
  );

  typedef struct {
    int          u;
    string       lbl;
    logic        em, es, cd;
    logic [31:0] ed;
    logic        cs, eb;
    logic [2:0]  ef;
    logic        cc;
    logic [31:0] eh, emc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  logic        p_cs = 1'b0, p_eb = 1'b0, p_cc = 1'b0;
  logic [2:0]  p_ef = 3'd0;
  logic [31:0] p_eh = 32'd0, p_em = 32'd0;

  task automatic chk(input string lbl, input string what, input int u,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s unit%0d got %h want %h", lbl, what, u, act, exp);
    end
  endtask

  task automatic set_st(input logic b, input logic [2:0] f);
    p_cs = 1'b1; p_eb = b; p_ef = f;
  endtask

  task automatic set_cnt(input logic [31:0] h, input logic [31:0] m);
    p_cc = 1'b1; p_eh = h; p_em = m;
  endtask

  task automatic cyc(input int u, input string lbl, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t,
                     input logic em, input logic es, input logic cd, input logic [31:0] ed);
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'd0; wd_s[i] = 32'd0; trd_s[i] = 3'd0;
    end
    rd_s[u] = rd; wr_s[u] = wr; addr_s[u] = a; wd_s[u] = wd; trd_s[u] = t;
    e.u = u; e.lbl = lbl; e.em = em; e.es = es; e.cd = cd; e.ed = ed;
    e.cs = p_cs; e.eb = p_eb; e.ef = p_ef; e.cc = p_cc; e.eh = p_eh; e.emc = p_em;
    q.push_back(e);
    $display("req %s unit%0d rd=%0b wr=%0b addr=%h trd=%0d", lbl, u, rd, wr, a, t);
    p_cs = 1'b0; p_cc = 1'b0;
  endtask

  task automatic idle(input int u, input int n, input string lbl);
    for (int k = 0; k < n; k++)
      cyc(u, lbl, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.lbl, "miss", e.u, 32'(miss_s[e.u]), 32'(e.em));
        chk(e.lbl, "segfault", e.u, 32'(seg_s[e.u]), 32'(e.es));
        if (e.cd) chk(e.lbl, "rd_data", e.u, rdd_s[e.u], e.ed);
        if (e.cs) begin
          chk(e.lbl, "busy", e.u, 32'(busy_s[e.u]), 32'(e.eb));
          chk(e.lbl, "fill_trd", e.u, 32'(ftrd_s[e.u]), 32'(e.ef));
        end
        if (e.cc) begin
          chk(e.lbl, "hit_cnt", e.u, hc_s[e.u], e.eh);
          chk(e.lbl, "miss_cnt", e.u, mc_s[e.u], e.emc);
        end
      end
    end
  end

  initial begin
    int waited;
    for (int i = 0; i < 2; i++) begin
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'd0; wd_s[i] = 32'd0; trd_s[i] = 3'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // cold miss, eight blocked retries, hit on the ninth
    set_st(1'b0, 3'd0); set_cnt(0, 0);
    cyc(0, "t1_first", 1, 0, 32'h40, 0, 3'd2, 1, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      set_st(1'b1, 3'd2);
      cyc(0, "t1_retry", 1, 0, 32'h40, 0, 3'd2, 1, 0, 1, 0);
    end
    set_st(1'b0, 3'd2);
    cyc(0, "t1_hit", 1, 0, 32'h40, 0, 3'd2, 0, 0, 0, 0);
    set_cnt(1, 9);
    idle(0, 1, "t1_cnt");

    // store/load on filled line, then neighbouring line misses and fills for trd 1
    cyc(0, "t2_wr", 0, 1, 32'h44, 32'hDEADBEEF, 3'd0, 0, 0, 0, 0);
    set_cnt(2, 9);
    cyc(0, "t2_rd", 1, 0, 32'h44, 0, 3'd0, 0, 0, 1, 32'hDEADBEEF);
    set_cnt(3, 9); set_st(1'b0, 3'd2);
    cyc(0, "t2_next", 1, 0, 32'h50, 0, 3'd1, 1, 0, 1, 0);
    set_st(1'b1, 3'd1);
    cyc(0, "t3_other", 1, 0, 32'h80, 0, 3'd5, 1, 0, 1, 0);
    set_st(1'b1, 3'd1);
    idle(0, 7, "t3_wait");
    set_st(1'b0, 3'd1); set_cnt(3, 11);
    cyc(0, "t3_hit", 1, 0, 32'h50, 0, 3'd1, 0, 0, 0, 0);
    set_st(1'b0, 3'd1);
    cyc(0, "t3_notvalid", 1, 0, 32'h80, 0, 3'd5, 1, 0, 1, 0);
    set_st(1'b1, 3'd5);
    idle(0, 9, "t3_drain");
    set_st(1'b0, 3'd5); set_cnt(4, 12);
    idle(0, 1, "t3_cnt");

    // illegal requests leave everything untouched
    set_st(1'b0, 3'd5);
    cyc(0, "t4_unalign", 1, 0, 32'h42, 0, 3'd0, 0, 1, 1, 0);
    set_st(1'b0, 3'd5);
    cyc(0, "t4_range", 1, 0, 32'h1000, 0, 3'd0, 0, 1, 1, 0);
    set_st(1'b0, 3'd5);
    cyc(0, "t4_rdwr", 1, 1, 32'h44, 32'h11111111, 3'd0, 0, 1, 1, 0);
    set_st(1'b0, 3'd5); set_cnt(4, 12);
    cyc(0, "t4_intact", 1, 0, 32'h44, 0, 3'd0, 0, 0, 1, 32'hDEADBEEF);
    cyc(0, "t4_lastword", 1, 0, 32'hFFC, 0, 3'd7, 1, 0, 1, 0);
    idle(0, 9, "t4_drain");

    // conflict eviction on index 0
    set_cnt(5, 13);
    cyc(0, "t5_a_miss", 1, 0, 32'h000, 0, 3'd3, 1, 0, 1, 0);
    idle(0, 8, "t5_fill_a");
    cyc(0, "t5_a_hit", 1, 0, 32'h000, 0, 3'd3, 0, 0, 0, 0);
    set_st(1'b0, 3'd3);
    cyc(0, "t5_b_miss", 1, 0, 32'h100, 0, 3'd4, 1, 0, 1, 0);
    idle(0, 8, "t5_fill_b");
    set_st(1'b0, 3'd4);
    cyc(0, "t5_b_hit", 1, 0, 32'h100, 0, 3'd4, 0, 0, 0, 0);
    set_cnt(7, 15);
    cyc(0, "t5_a_evicted", 1, 0, 32'h000, 0, 3'd3, 1, 0, 1, 0);

    // reset during the fourth fill cycle
    set_st(1'b1, 3'd3);
    idle(0, 3, "t6_fill");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_st(1'b0, 3'd0); set_cnt(0, 0);
    idle(0, 1, "t6_after_rst");
    set_st(1'b0, 3'd0);
    cyc(0, "t6_not_installed", 1, 0, 32'h000, 0, 3'd6, 1, 0, 1, 0);
    set_st(1'b1, 3'd6);
    idle(0, 9, "t6_drain");

    // miss-free build
    set_st(1'b0, 3'd0); set_cnt(0, 0);
    cyc(1, "m0_rd", 1, 0, 32'h40, 0, 3'd1, 0, 0, 0, 0);
    cyc(1, "m0_wr", 0, 1, 32'h80, 32'h12345678, 3'd1, 0, 0, 0, 0);
    cyc(1, "m0_rdback", 1, 0, 32'h80, 0, 3'd1, 0, 0, 1, 32'h12345678);
    cyc(1, "m0_other", 1, 0, 32'h100, 0, 3'd2, 0, 0, 0, 0);
    cyc(1, "m0_seg", 1, 0, 32'h1000, 0, 3'd2, 0, 1, 1, 0);
    set_st(1'b0, 3'd0); set_cnt(4, 0);
    idle(1, 1, "m0_cnt");

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
